// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared FSM state type and geometry constants for the data cache
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

  localparam int OFF_W     = 5;
  localparam int IDX_W     = 5;
  localparam int TAG_W     = 32 - IDX_W - OFF_W;
  localparam int LINE_BITS = 256;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MISS        = 3'd1,
    WRITEBACK   = 3'd2,
    REFILL      = 3'd3,
    REFILL_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_sram.sv
// ============================================================================
// dcache_sram : direct-mapped tag/valid/dirty/data storage, sync write, async read
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dcache_sram #(
  parameter int NUM_LINES = 32,
  parameter int IDX_BITS  = 5,
  parameter int TAG_BITS  = 22,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_BITS-1:0]  idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_BITS-1:0]  tag_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 wr_en_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_line_i,
  input  logic                 wr_dirty_i
);

  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = wr_dirty_i;
    end
  end

  // Only the state bits are reset; tag and data contents are don't-care until valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_line_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : blocking write-back, write-allocate direct-mapped data cache controller
//               Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic                 stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  import dcache_pkg::*;

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = TAG_W + IDX_W - IDX_BITS;

  state_e state_q, state_d;

  logic [TAG_BITS-1:0]  req_tag;
  logic [IDX_BITS-1:0]  req_idx;
  logic [7:0]           word_lsb;
  logic                 access;
  logic                 hit;
  logic                 line_valid, line_dirty;
  logic [TAG_BITS-1:0]  line_tag;
  logic [LINE_BITS-1:0] line_data;
  logic [LINE_BITS-1:0] merged_line;
  logic                 wr_en;
  logic [LINE_BITS-1:0] wr_line;
  logic                 wr_dirty;
  logic                 unused_ok;

  assign req_tag   = addr_i[31 -: TAG_BITS];
  assign req_idx   = addr_i[OFF_W +: IDX_BITS];
  assign word_lsb  = {addr_i[4:2], 5'd0};
  assign access    = MemRead_i | MemWrite_i;
  assign hit       = line_valid && (line_tag == req_tag);
  assign data_o    = hit ? line_data[word_lsb +: 32] : 32'd0;
  assign unused_ok = ^addr_i[1:0];

  always_comb begin
    merged_line = line_data;
    merged_line[word_lsb +: 32] = data_i;
  end

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (req_idx),
    .valid_o    (line_valid),
    .dirty_o    (line_dirty),
    .tag_o      (line_tag),
    .line_o     (line_data),
    .wr_en_i    (wr_en & ~rst_i),
    .wr_tag_i   (req_tag),
    .wr_line_i  (wr_line),
    .wr_dirty_i (wr_dirty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The victim always sits at the request index, so both memory addresses reuse req_idx.
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b1;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = '0;
    wr_en        = 1'b0;
    wr_line      = merged_line;
    wr_dirty     = 1'b1;
    case (state_q)
      IDLE: begin
        stall_o = 1'b0;
        if (access) begin
          if (hit) begin
            wr_en = MemWrite_i;
          end else begin
            stall_o = 1'b1;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        state_d = (line_valid && line_dirty) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag, req_idx, 5'd0};
        mem_data_o   = line_data;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, 5'd0};
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_line  = mem_data_i;
          wr_dirty = 1'b0;
          state_d  = REFILL_DONE;
        end
      end
      REFILL_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        after_fill_q, after_fill_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // The hit that completes a miss is not counted as a separate hit.
  always_comb begin
    after_fill_d = (state_q == REFILL_DONE);
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (state_q == IDLE && access) begin
      if (hit && !after_fill_q) hit_cnt_d  = hit_cnt_q + 32'd1;
      if (!hit)                 miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      after_fill_q <= 1'b0;
      hit_cnt_q    <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      after_fill_q <= after_fill_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

`default_nettype wire
